// File: rtl/otter_csr_pkg.sv
// rtl/otter_csr_pkg.sv - CSR addresses, op encoding and field constants for the OTTER CSR/IRQ unit
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Interrupt line i maps to mip/mie bit and cause code IRQ_CAUSE_BASE + i.
  localparam int IRQ_CAUSE_BASE = 16;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-stage synchroniser for asynchronous level interrupt lines
module irq_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_irq,
  output logic [WIDTH-1:0] o_irq
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_irq;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_irq = r_stage[STAGES-1];

endmodule

// File: rtl/csr_irq_unit.sv
// rtl/csr_irq_unit.sv - machine-mode CSR file, cycle counter and prioritised interrupt/trap unit
module csr_irq_unit
  import otter_csr_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_csr_op,
  input  logic [11:0]        i_addr,
  input  logic [31:0]        i_wd,
  input  logic [31:0]        i_pc,
  input  logic               i_instr_boundary,
  input  logic               i_mret_exec,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic [31:0]        o_rd,
  output logic               o_illegal,
  output logic               o_trap_taken,
  output logic [31:0]        o_trap_vec,
  output logic [31:0]        o_mepc,
  output logic               o_mie
);

  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [NUM_IRQ-1:0] r_mie_en;
  logic [31:0]        r_mtvec;
  logic [29:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [63:0]        r_mcycle;

  logic [NUM_IRQ-1:0] w_mip;
  logic [NUM_IRQ-1:0] w_pending;
  logic [4:0]         w_irq_idx;
  logic [4:0]         w_cause_code;
  logic               w_trap;
  logic [31:0]        w_vec_base;
  logic [31:0]        w_rd;
  logic               w_mapped;
  logic               w_illegal;
  logic [31:0]        w_new;
  logic               w_csr_we;
  logic [1:0]         w_mtvec_mode;
  logic [63:0]        w_mcycle_next;
  logic               w_unused;

  irq_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_irq (i_irq),
    .o_irq (w_mip)
  );

  assign w_pending = w_mip & r_mie_en;

  // Scan from the top so the lowest pending index is the last assignment and wins.
  always_comb begin
    w_irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) w_irq_idx = 5'(i);
    end
  end

  assign w_cause_code = 5'(IRQ_CAUSE_BASE) + w_irq_idx;
  assign w_trap       = i_instr_boundary & r_mstatus_mie & (|w_pending);
  assign w_vec_base   = {r_mtvec[31:2], 2'b00};
  assign o_trap_vec   = (r_mtvec[1:0] == MTVEC_MODE_VECTORED)
                      ? w_vec_base + {25'd0, w_cause_code, 2'b00}
                      : w_vec_base;

  always_comb begin
    w_rd     = '0;
    w_mapped = 1'b1;
    case (i_addr)
      CSR_MSTATUS: begin
        w_rd[MSTATUS_MIE_BIT]  = r_mstatus_mie;
        w_rd[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
      end
      CSR_MIE:     w_rd[IRQ_CAUSE_BASE +: NUM_IRQ] = r_mie_en;
      CSR_MTVEC:   w_rd = r_mtvec;
      CSR_MEPC:    w_rd = {r_mepc, 2'b00};
      CSR_MCAUSE:  w_rd = r_mcause;
      CSR_MIP:     w_rd[IRQ_CAUSE_BASE +: NUM_IRQ] = w_mip;
      CSR_MCYCLE:  w_rd = r_mcycle[31:0];
      CSR_MCYCLEH: w_rd = r_mcycle[63:32];
      default:     w_mapped = 1'b0;
    endcase
  end

  assign w_illegal = (i_csr_op != CSR_OP_NONE) && (!w_mapped || (i_addr == CSR_MIP));
  assign w_csr_we  = (i_csr_op != CSR_OP_NONE) && !w_illegal && !w_trap;

  always_comb begin
    w_new = w_rd;
    case (csr_op_e'(i_csr_op))
      CSR_OP_WRITE: w_new = i_wd;
      CSR_OP_SET:   w_new = w_rd | i_wd;
      CSR_OP_CLEAR: w_new = w_rd & ~i_wd;
      default:      w_new = w_rd;
    endcase
  end

  // Reserved MODE encodings collapse to direct.
  assign w_mtvec_mode = (w_new[1:0] == MTVEC_MODE_VECTORED) ? MTVEC_MODE_VECTORED
                                                             : MTVEC_MODE_DIRECT;

  always_comb begin
    w_mcycle_next = r_mcycle + 64'd1;
    if (w_csr_we && (i_addr == CSR_MCYCLE)) begin
      w_mcycle_next = {r_mcycle[63:32], w_new};
    end else if (w_csr_we && (i_addr == CSR_MCYCLEH)) begin
      w_mcycle_next = {w_new, r_mcycle[31:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_en       <= '0;
      r_mtvec        <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mcycle       <= '0;
    end else begin
      r_mcycle <= w_mcycle_next;
      if (w_trap) begin
        r_mepc         <= i_pc[31:2];
        r_mcause       <= {1'b1, 26'd0, w_cause_code};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else begin
        if (w_csr_we) begin
          case (i_addr)
            CSR_MSTATUS: begin
              if (!i_mret_exec) begin
                r_mstatus_mie  <= w_new[MSTATUS_MIE_BIT];
                r_mstatus_mpie <= w_new[MSTATUS_MPIE_BIT];
              end
            end
            CSR_MIE:    r_mie_en <= w_new[IRQ_CAUSE_BASE +: NUM_IRQ];
            CSR_MTVEC:  r_mtvec  <= {w_new[31:2], w_mtvec_mode};
            CSR_MEPC:   r_mepc   <= w_new[31:2];
            CSR_MCAUSE: r_mcause <= w_new;
            default:    ;
          endcase
        end
        if (i_mret_exec) begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
        end
      end
    end
  end

  assign o_rd         = w_rd;
  assign o_illegal    = w_illegal;
  assign o_trap_taken = w_trap;
  assign o_mepc       = {r_mepc, 2'b00};
  assign o_mie        = r_mstatus_mie;

  assign w_unused = ^i_pc[1:0];

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb/tb_csr_irq_unit.sv - directed self-checking bench for csr_irq_unit
module tb_csr_irq_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_csr_op = 2'd0;
  logic [11:0] i_addr = 12'h0;
  logic [31:0] i_wd = 32'h0;
  logic [31:0] i_pc = 32'h0;
  logic        i_instr_boundary = 1'b0;
  logic        i_mret_exec = 1'b0;
  logic [3:0]  i_irq = 4'h0;
  logic [31:0] o_rd;
  logic        o_illegal;
  logic        o_trap_taken;
  logic [31:0] o_trap_vec;
  logic [31:0] o_mepc;
  logic        o_mie;

  int checks = 0;
  int errors = 0;

  csr_irq_unit #(.NUM_IRQ(4), .SYNC_STAGES(2)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_csr_op         (i_csr_op),
    .i_addr           (i_addr),
    .i_wd             (i_wd),
    .i_pc             (i_pc),
    .i_instr_boundary (i_instr_boundary),
    .i_mret_exec      (i_mret_exec),
    .i_irq            (i_irq),
    .o_rd             (o_rd),
    .o_illegal        (o_illegal),
    .o_trap_taken     (o_trap_taken),
    .o_trap_vec       (o_trap_vec),
    .o_mepc           (o_mepc),
    .o_mie            (o_mie)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    i_csr_op = op;
    i_addr   = a;
    i_wd     = d;
    step();
    i_csr_op = 2'd0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    i_csr_op = 2'd0;
    i_addr   = a;
    #1;
    d = o_rd;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [8];
    logic [31:0] v;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80};
    i_rst = 1'b1;
    step();
    step();
    foreach (addrs[k]) begin
      rd(addrs[k], v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd[%h]: got %h expected %h", addrs[k], v, 32'h0);
      end
    end
    checks++;
    if ({o_mie, o_trap_taken, o_illegal} !== 3'b000 || o_mepc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got mie=%b trap=%b ill=%b mepc=%h expected 0", o_mie, o_trap_taken, o_illegal, o_mepc);
    end
    i_rst = 1'b0;
    repeat (5) step();
    rd(12'hB00, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("FAIL mcycle_after_5: got %0d expected 5", v);
    end
  endtask

  task automatic test_mcycle_wrap();
    logic [31:0] lo, hi;
    csr(2'd1, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, lo);
    rd(12'hB80, hi);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h0) begin
      errors++;
      $display("FAIL mcycle_write: got %h_%h expected 00000000_ffffffff", hi, lo);
    end
    step();
    rd(12'hB00, lo);
    rd(12'hB80, hi);
    checks++;
    if (lo !== 32'h0 || hi !== 32'h1) begin
      errors++;
      $display("FAIL mcycle_carry: got %h_%h expected 00000001_00000000", hi, lo);
    end
  endtask

  task automatic test_direct_trap();
    logic [31:0] v;
    csr(2'd1, 12'h305, 32'h100);
    csr(2'd1, 12'h304, 32'h0001_0000);
    csr(2'd1, 12'h300, 32'h8);
    i_pc = 32'h2000;
    i_instr_boundary = 1'b1;
    i_irq = 4'b0001;
    step();
    checks++;
    if (o_trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL trap_early: got %b expected 0", o_trap_taken);
    end
    step();
    checks++;
    if (o_trap_taken !== 1'b1 || o_trap_vec !== 32'h100) begin
      errors++;
      $display("FAIL direct_trap: got taken=%b vec=%h expected 1 00000100", o_trap_taken, o_trap_vec);
    end
    rd(12'h344, v);
    checks++;
    if (v !== 32'h0001_0000) begin
      errors++;
      $display("FAIL mip_irq0: got %h expected 00010000", v);
    end
    step();
    i_instr_boundary = 1'b0;
    checks++;
    if (o_mepc !== 32'h2000 || o_mie !== 1'b0) begin
      errors++;
      $display("FAIL trap_entry_mepc: got mepc=%h mie=%b expected 00002000 0", o_mepc, o_mie);
    end
    rd(12'h342, v);
    checks++;
    if (v !== 32'h8000_0010) begin
      errors++;
      $display("FAIL trap_mcause: got %h expected 80000010", v);
    end
    rd(12'h300, v);
    checks++;
    if (v !== 32'h80) begin
      errors++;
      $display("FAIL trap_mstatus: got %h expected 00000080", v);
    end
  endtask

  task automatic test_mret();
    logic [31:0] v;
    i_mret_exec = 1'b1;
    step();
    i_mret_exec = 1'b0;
    rd(12'h300, v);
    checks++;
    if (v !== 32'h88 || o_mie !== 1'b1) begin
      errors++;
      $display("FAIL mret: got mstatus=%h mie=%b expected 00000088 1", v, o_mie);
    end
    i_mret_exec = 1'b1;
    csr(2'd3, 12'h300, 32'h8);
    i_mret_exec = 1'b0;
    rd(12'h300, v);
    checks++;
    if (v !== 32'h88) begin
      errors++;
      $display("FAIL mret_vs_clear: got %h expected 00000088", v);
    end
    i_mret_exec = 1'b1;
    csr(2'd1, 12'h342, 32'h55);
    i_mret_exec = 1'b0;
    rd(12'h342, v);
    checks++;
    if (v !== 32'h55) begin
      errors++;
      $display("FAIL mret_other_csr: got %h expected 00000055", v);
    end
    i_irq = 4'b0000;
    step();
    step();
  endtask

  task automatic test_vectored();
    logic [31:0] v;
    csr(2'd1, 12'h305, 32'h101);
    csr(2'd1, 12'h304, 32'h000F_0000);
    i_irq = 4'b1100;
    step();
    step();
    rd(12'h344, v);
    checks++;
    if (v !== 32'h000C_0000 || o_trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL vec_gate: got mip=%h taken=%b expected 000c0000 0", v, o_trap_taken);
    end
    i_pc = 32'h3006;
    i_instr_boundary = 1'b1;
    #1;
    checks++;
    if (o_trap_taken !== 1'b1 || o_trap_vec !== 32'h148) begin
      errors++;
      $display("FAIL vectored_trap: got taken=%b vec=%h expected 1 00000148", o_trap_taken, o_trap_vec);
    end
    step();
    i_instr_boundary = 1'b0;
    rd(12'h342, v);
    checks++;
    if (v !== 32'h8000_0012 || o_mepc !== 32'h3004) begin
      errors++;
      $display("FAIL vec_entry: got mcause=%h mepc=%h expected 80000012 00003004", v, o_mepc);
    end
  endtask

  task automatic test_set_clear_illegal();
    logic [31:0] v;
    csr(2'd1, 12'h300, 32'h0);
    csr(2'd2, 12'h300, 32'h8);
    rd(12'h300, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("FAIL mstatus_set: got %h expected 00000008", v);
    end
    csr(2'd3, 12'h300, 32'h8);
    rd(12'h300, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL mstatus_clear: got %h expected 00000000", v);
    end
    csr(2'd1, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, v);
    checks++;
    if (v !== 32'h88) begin
      errors++;
      $display("FAIL mstatus_mask: got %h expected 00000088", v);
    end
    csr(2'd1, 12'h300, 32'h0);
    csr(2'd1, 12'h305, 32'h103);
    rd(12'h305, v);
    checks++;
    if (v !== 32'h100) begin
      errors++;
      $display("FAIL mtvec_mode3: got %h expected 00000100", v);
    end
    csr(2'd1, 12'h341, 32'h1237);
    checks++;
    if (o_mepc !== 32'h1234) begin
      errors++;
      $display("FAIL mepc_align: got %h expected 00001234", o_mepc);
    end
    i_csr_op = 2'd1;
    i_addr = 12'h344;
    i_wd = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (o_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_mip: got %b expected 1", o_illegal);
    end
    step();
    i_csr_op = 2'd2;
    i_addr = 12'h7C0;
    #1;
    checks++;
    if (o_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_unmapped: got %b expected 1", o_illegal);
    end
    step();
    i_csr_op = 2'd0;
    #1;
    checks++;
    if (o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_noop: got %b expected 0", o_illegal);
    end
    rd(12'h344, v);
    checks++;
    if (v !== 32'h000C_0000 || o_mepc !== 32'h1234) begin
      errors++;
      $display("FAIL illegal_nochange: got mip=%h mepc=%h expected 000c0000 00001234", v, o_mepc);
    end
  endtask

  task automatic test_trap_priority_reset();
    logic [31:0] v;
    logic [11:0] addrs [7];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB80};
    csr(2'd1, 12'h300, 32'h8);
    i_instr_boundary = 1'b1;
    i_csr_op = 2'd1;
    i_addr = 12'h305;
    i_wd = 32'hDEAD;
    #1;
    checks++;
    if (o_trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL trap_vs_write_taken: got %b expected 1", o_trap_taken);
    end
    step();
    i_csr_op = 2'd0;
    i_instr_boundary = 1'b0;
    rd(12'h305, v);
    checks++;
    if (v !== 32'h100) begin
      errors++;
      $display("FAIL trap_vs_write_mtvec: got %h expected 00000100", v);
    end
    i_rst = 1'b1;
    step();
    foreach (addrs[k]) begin
      rd(addrs[k], v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL post_trap_reset[%h]: got %h expected 00000000", addrs[k], v);
      end
    end
    checks++;
    if (o_mie !== 1'b0 || o_mepc !== 32'h0) begin
      errors++;
      $display("FAIL post_trap_reset_out: got mie=%b mepc=%h expected 0 00000000", o_mie, o_mepc);
    end
    i_rst = 1'b0;
    i_irq = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_mcycle_wrap();
    test_direct_trap();
    test_mret();
    test_vectored();
    test_set_clear_illegal();
    test_trap_priority_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_irq_unit.md
# csr_irq_unit

Parametrised machine-mode CSR and interrupt unit for the OTTER MCU. It holds `mstatus`, `mie`, `mtvec`, `mepc`, `mcause`, `mip` and a 64-bit `mcycle`, and executes CSRRW/CSRRS/CSRRC-style updates. It arbitrates `NUM_IRQ` prioritised interrupt lines and produces the trap target PC in direct or vectored mode. It sits beside the control unit and PC mux; the control unit presents instruction boundaries and `mret`, and consumes `TRAP_TAKEN`/`TRAP_VEC`.

## Interface
- `NUM_IRQ`, default 4: number of platform interrupt lines, range 1..16.
- `SYNC_STAGES`, default 2: flops in each IRQ synchroniser, 1..3.
- `CLK  in  1`: single clock; everything samples on the rising edge.
- `RST  in  1`: reset; synchronous, active-high.
- `CSR_OP  in  2`: 0 none, 1 write, 2 set bits, 3 clear bits.
- `ADDR  in  12`: CSR address.
- `WD  in  32`: write / set / clear operand.
- `PC  in  32`: PC to save in `mepc` when a trap is taken.
- `INSTR_BOUNDARY  in  1`: control unit is at an interruptible point.
- `MRET_EXEC  in  1`: an `mret` retires this cycle.
- `IRQ  in  NUM_IRQ`: asynchronous, level-sensitive interrupt requests.
- `RD  out  32`: combinational read data for `ADDR`.
- `ILLEGAL  out  1`: `CSR_OP`≠0 targets an unmapped CSR, or a write/set/clear targets a read-only CSR.
- `TRAP_TAKEN  out  1`: the interrupt is accepted this cycle.
- `TRAP_VEC  out  32`: handler address, valid while `TRAP_TAKEN`=1.
- `MEPC  out  32`: current `mepc`, used by `mret`.
- `MIE  out  1`: `mstatus.MIE`.

## Operation

CSR map. Unmapped addresses read 0.
- `mstatus` 0x300: only bit 3 (MIE) and bit 7 (MPIE) are implemented; all other bits read 0 and ignore writes.
- `mie` 0x304: bits [16+NUM_IRQ-1:16] are implemented; all other bits read 0.
- `mtvec` 0x305: bits [1:0] are MODE (0 direct, 1 vectored); values 2 and 3 are stored as 0.
- `mepc` 0x341: bits [1:0] are hard-wired to 0.
- `mcause` 0x342: fully writable.
- `mip` 0x344: read-only; bit 16+i holds synchronised `IRQ[i]`.
- `mcycle`/`mcycleh` 0xB00/0xB80: low and high words of a 64-bit free-running counter.

CSR updates, applied to implemented bits only:
- write: new = WD.
- set: new = old | WD.
- clear: new = old & ~WD.

Pending and priority:
- pending = `mip & mie`.
- Lowest index i wins.
- `TRAP_TAKEN` = `INSTR_BOUNDARY` & MIE & |pending.

Trap entry, on the edge ending a `TRAP_TAKEN` cycle:
- `mepc` ← {PC[31:2],00}.
- `mcause` ← {1, 31'(16+i)}.
- MPIE ← MIE; MIE ← 0.

`TRAP_VEC`:
- direct mode: {mtvec[31:2],00}.
- vectored mode: {mtvec[31:2],00} + 4·(16+i).

`mret`: MIE ← MPIE; MPIE ← 1.

`mcycle`:
- Increments by 1 every cycle, carrying into the high word; the 0xFFFF_FFFF_FFFF_FFFF → 0 wrap is silent.
- A CSR write to either half replaces that half; the increment is dropped that cycle.

Simultaneous events, in priority order:
1. `RST` beats everything.
2. Trap entry beats `mret` and any CSR update; the CSR update is discarded and the `mret` is ignored.
3. `mret` with a CSR update to `mstatus`: `mret` wins for MIE/MPIE.
4. CSR updates to other registers in an `mret` cycle proceed.
- An illegal access changes no state.

## Timing
- Reset value 0 for: `mstatus`, `mie`, `mtvec`, `mepc`, `mcause`, `mcycle`, and the synchroniser flops.
- Reset output values: `MIE`=0, `MEPC`=0, `TRAP_TAKEN`=0, `ILLEGAL`=0; `RD`=0 for all addresses except 0xB00, which reads the counter.
- `RD`, `ILLEGAL`, `TRAP_TAKEN`, `TRAP_VEC`: combinational; `RD` returns the pre-update value in the update cycle.
- CSR updates, trap entry and `mret` are visible on outputs and `RD` the cycle after the edge.
- `IRQ` edge → `mip` bit: `SYNC_STAGES` cycles.
- With MIE=1 and the line enabled, `IRQ` rise → `TRAP_TAKEN` is possible after `SYNC_STAGES` cycles, gated by `INSTR_BOUNDARY`.
- `mcycle` reads N at reset release + N cycles.

## Structure
- Package `otter_csr_pkg`:
  - CSR address localparams.
  - `csr_op_e` enum.
  - `mtvec` mode constants.
  - mstatus bit indices (MIE=3, MPIE=7).
  - IRQ cause base (16).
- Sub-module `irq_sync`: `NUM_IRQ`-wide, `SYNC_STAGES`-deep synchroniser with synchronous reset.

## Test plan
- `RST` held 2 cycles → all reads 0; `mcycle` reads 5 after 5 cycles post-reset; write 0xFFFF_FFFF to 0xB00 → next cycle low word = 0 and high word = 1.
- Write `mtvec`=0x100 (direct), `mie`=0x0001_0000, `mstatus`=0x8; raise `IRQ[0]`; hold `INSTR_BOUNDARY`=1, PC=0x2000 → `TRAP_TAKEN`=1 exactly 2 cycles later, `TRAP_VEC`=0x100; next cycle `MEPC`=0x2000, `mcause`=0x8000_0010, `mstatus`=0x80.
- Vectored mode: `mtvec`=0x101, `mie`=0x000F_0000, `IRQ`=4'b1100 → `TRAP_VEC`=0x100+4·18=0x148, `mcause`=0x8000_0012.
- `mret` after a trap → `mstatus`=0x88, `MIE`=1; `mret` in the same cycle as a CSR clear of `mstatus` bit 3 → `mstatus`=0x88.
- Set 0x8 on `mstatus` then clear 0x8 → 0x8 then 0x0; write to `mip` or 0x7C0 → `ILLEGAL`=1 and no state change.
- Trap in the same cycle as a write of 0xDEAD to `mtvec` → `mtvec` unchanged; `RST` asserted one cycle after trap entry → every register 0 on the next cycle.
